mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous main memory between two requesters: port 0 = CPU sequence controller (fetch/LD/ST/STX), port 1 = program loader/debug port.
- Sits between the requesters and the memory's MEM_En/MEM_Wr/address/data pins.
- Registers each winning command, drives one memory access, and returns read data with a one-cycle Ack.
- Bounds consecutive grants to one port so the loader cannot be starved by the CPU.

Parameters:
DataWidth, 16, memory word width
AddrWidth, 8, memory address width
BurstMax, 4, max consecutive grants to one port while the other port is requesting (1..15)

Ports:
Clk  in  1  clock, all state changes on rising edge
Reset  in  1  synchronous, active-low
Req0, Req1  in  1  access request, active high
Wr0, Wr1  in  1  1 = read, 0 = write (memory MEM_Wr polarity)
Addr0, Addr1  in  AddrWidth  access address
WData0, WData1  in  DataWidth  write data
Gnt0, Gnt1  out  1  grant pulse, command captured
Ack0, Ack1  out  1  access complete pulse
RData0, RData1  out  DataWidth  read data, valid while AckN high, held afterwards
MEM_En  out  1  memory enable, active low
MEM_Wr  out  1  1 = read, 0 = write
MEM_Addr  out  AddrWidth  registered address
MEM_WData  out  DataWidth  registered write data
MEM_RData  in  DataWidth  memory read data, valid the cycle after MEM_En low
Busy  out  1  high in S_Access and S_Resp

Behaviour:
Reset (Reset == 0 at posedge):
- state = S_Idle, burst count = 0, last-owner = port 1.
- MEM_En = 1, MEM_Wr = 1, MEM_Addr = 0, MEM_WData = 0.
- Gnt0/1 = 0, Ack0/1 = 0, RData0/1 = 0, Busy = 0.
- Reset overrides all other inputs.
- Reset mid-access: the in-flight access is abandoned. No Ack is issued and MEM_En returns high on that edge.
- All outputs are registered.

States:
- S_Idle: no access.
- S_Access: MEM_En = 0, GntN = 1 for the owner only. Exactly one cycle.
- S_Resp: MEM_En = 1. For a read, RDataN <= MEM_RData on entry and AckN = 1. For a write, AckN = 1 and RDataN is unchanged. Exactly one cycle.

Arbitration (evaluated in S_Idle and S_Resp on sampled Req0/Req1):
- Neither requesting: next state S_Idle.
- One requesting: that port wins.
- Both requesting: port 0 wins, unless last owner = 0 and burst count == BurstMax, in which case port 1 wins.
- Winner's Wr/Addr/WData are latched into MEM_Wr/MEM_Addr/MEM_WData. Next state S_Access.
- S_Resp -> S_Access directly on a new win (back-to-back), giving 1 access per 2 cycles sustained.

Burst count:
- Increments when the winner equals the last owner, saturating at BurstMax.
- Resets to 1 when ownership changes.
- Resets to 0 when the arbiter enters S_Idle.

Latency: Req sampled high in S_Idle at edge T gives Gnt high in cycle T..T+1 and Ack/RData in cycle T+1..T+2.

Handshake rules:
- Requester holds Req and its command stable until it sees GntN.
- It deasserts Req on the edge after GntN unless it wants another access.
- Req still high in S_Resp is treated as a new request.
- Command changes after Gnt do not affect the captured access.
- Gnt and Ack are never high for both ports in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both ports request, the winner is always the port that is not the last owner (strict round-robin). BurstMax and the burst count are ignored (count logic removed).
- Undefined: fixed priority to port 0 with the BurstMax limit, as described above.

Test Plan:
- Mem[0x12] = 0xBEEF; Req0 = 1, Wr0 = 1, Addr0 = 0x12 in S_Idle at edge T -> cycle T+1: Gnt0 = 1, MEM_En = 0, MEM_Addr = 0x12, MEM_Wr = 1. Cycle T+2: Ack0 = 1, RData0 = 0xBEEF, MEM_En = 1, Gnt1/Ack1 = 0.
- Req1 = 1, Wr1 = 0, Addr1 = 0x34, WData1 = 0x1234 -> Gnt1 then Ack1 one cycle each. MEM_Wr = 0 during S_Access. A later port-0 read of 0x34 returns 0x1234. RData1 is unchanged.
- Req0 and Req1 both high in S_Idle, each dropped after its Gnt -> port 0 served first, port 1 granted the cycle after Ack0 (back-to-back). Total 4 cycles, Busy high throughout.
- BurstMax = 4, Req0 held high continuously, Req1 raised -> at most 4 consecutive Gnt0 while Req1 pending, then Gnt1. With MEM_ARB_RR_EN defined, Gnt0/Gnt1 alternate every access.
- Reset = 0 asserted during S_Access of a port-0 read -> next cycle MEM_En = 1, Busy = 0, Ack0 never pulses, RData0 = 0. Normal operation resumes after Reset = 1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side signals of the
// two-port memory arbiter. The arbiter connects through the slave modport.
// The master modport is the view from the requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
);
    logic                 Req0, Req1;
    logic                 Wr0, Wr1;
    logic [AddrWidth-1:0] Addr0, Addr1;
    logic [DataWidth-1:0] WData0, WData1;
    logic                 Gnt0, Gnt1;
    logic                 Ack0, Ack1;
    logic [DataWidth-1:0] RData0, RData1;
    logic                 MEM_En;
    logic                 MEM_Wr;
    logic [AddrWidth-1:0] MEM_Addr;
    logic [DataWidth-1:0] MEM_WData;
    logic [DataWidth-1:0] MEM_RData;
    logic                 Busy;

    modport slave (
        input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, MEM_RData,
        output Gnt0, Gnt1, Ack0, Ack1, RData0, RData1,
        output MEM_En, MEM_Wr, MEM_Addr, MEM_WData, Busy
    );

    modport master (
        output Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, MEM_RData,
        input  Gnt0, Gnt1, Ack0, Ack1, RData0, RData1,
        input  MEM_En, MEM_Wr, MEM_Addr, MEM_WData, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between port 0 (CPU
// sequencer) and port 1 (loader/debug). Each won command is registered,
// drives one memory access cycle, and is acknowledged one cycle later.
// Default arbitration: port 0 priority, limited to BurstMax consecutive
// grants while port 1 waits. Define MEM_ARB_RR_EN for strict round-robin
// between the ports when both request (burst counter removed).
module mem_port_arbiter #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8,
    parameter int BurstMax  = 4
) (
    input  logic Clk,
    input  logic Reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_Idle   = 2'd0;
    localparam logic [1:0] S_Access = 2'd1;
    localparam logic [1:0] S_Resp   = 2'd2;

    logic [1:0]           state;
    logic                 last_owner;
    logic                 owner;
    logic                 win_valid;
    logic                 win_port;
    logic                 win_wr;
    logic [AddrWidth-1:0] win_addr;
    logic [DataWidth-1:0] win_wdata;
`ifndef MEM_ARB_RR_EN
    localparam logic [3:0] BurstLim = 4'(BurstMax);
    logic [3:0]           burst_cnt;
    logic [3:0]           burst_next;
`endif

    // Pick the winner from the sampled requests and mux its command.
    always_comb begin
        win_valid = bus.Req0 | bus.Req1;
        win_port  = bus.Req1;
        if (bus.Req0 && bus.Req1) begin
`ifdef MEM_ARB_RR_EN
            win_port = ~last_owner;
`else
            win_port = (!last_owner && (burst_cnt == BurstLim));
`endif
        end
        win_wr    = win_port ? bus.Wr1    : bus.Wr0;
        win_addr  = win_port ? bus.Addr1  : bus.Addr0;
        win_wdata = win_port ? bus.WData1 : bus.WData0;
`ifndef MEM_ARB_RR_EN
        if (win_port != last_owner)
            burst_next = 4'd1;
        else if (burst_cnt == BurstLim)
            burst_next = burst_cnt;
        else
            burst_next = burst_cnt + 4'd1;
`endif
    end

    // Arbiter state machine; every output is registered here.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= S_Idle;
            last_owner    <= 1'b1;
            owner         <= 1'b0;
`ifndef MEM_ARB_RR_EN
            burst_cnt     <= '0;
`endif
            bus.MEM_En    <= 1'b1;
            bus.MEM_Wr    <= 1'b1;
            bus.MEM_Addr  <= '0;
            bus.MEM_WData <= '0;
            bus.Gnt0      <= 1'b0;
            bus.Gnt1      <= 1'b0;
            bus.Ack0      <= 1'b0;
            bus.Ack1      <= 1'b0;
            bus.RData0    <= '0;
            bus.RData1    <= '0;
            bus.Busy      <= 1'b0;
        end else begin
            bus.Gnt0 <= 1'b0;
            bus.Gnt1 <= 1'b0;
            bus.Ack0 <= 1'b0;
            bus.Ack1 <= 1'b0;
            if (state == S_Access) begin
                // Access cycle ends: release memory, acknowledge the owner.
                state      <= S_Resp;
                bus.MEM_En <= 1'b1;
                bus.Busy   <= 1'b1;
                if (owner) bus.Ack1 <= 1'b1;
                else       bus.Ack0 <= 1'b1;
                if (bus.MEM_Wr) begin
                    if (owner) bus.RData1 <= bus.MEM_RData;
                    else       bus.RData0 <= bus.MEM_RData;
                end
            end else if (win_valid) begin
                // Idle or Resp with a request: start the next access.
                state         <= S_Access;
                bus.MEM_En    <= 1'b0;
                bus.MEM_Wr    <= win_wr;
                bus.MEM_Addr  <= win_addr;
                bus.MEM_WData <= win_wdata;
                bus.Busy      <= 1'b1;
                owner         <= win_port;
                last_owner    <= win_port;
`ifndef MEM_ARB_RR_EN
                burst_cnt     <= burst_next;
`endif
                if (win_port) bus.Gnt1 <= 1'b1;
                else          bus.Gnt0 <= 1'b1;
            end else begin
                state      <= S_Idle;
                bus.MEM_En <= 1'b1;
                bus.Busy   <= 1'b0;
`ifndef MEM_ARB_RR_EN
                burst_cnt  <= '0;
`endif
            end
        end
    end

endmodule
